sqrt_result_collector: RTL and testbench

SQRT_RESULT_COLLECTOR -- requirements
Module: sqrt_result_collector

---
 rtl/sqrt_result_collector_if.sv | 70 +++++++
 rtl/sqrt_result_collector.sv | 188 ++++++++++++++++++
 tb/tb_sqrt_result_collector.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sqrt_result_collector_if.sv
// ---------------------------------------------------------------------------
// sqrt_result_collector_if
//
// Purpose : groups the upstream argument/result strobes, the downstream
//           valid/ready result stream and the status outputs of
//           sqrt_result_collector into one bundle.
//
// Signals : arg_vld   - pulse per argument triple issued upstream
//           res_vld   - result valid from the sqrt distributor
//           res       - 32-bit result value
//           out_vld   - head-of-FIFO valid
//           out_ready - consumer ready
//           out_data  - head-of-FIFO result
//           fifo_cnt  - FIFO occupancy, clog2(DEPTH)+1 bits
//           in_flight - issued arguments whose results are outstanding
//           stall_req - asks the argument source to stop issuing
//           overflow  - sticky, a result was dropped
//           underflow - sticky, a result arrived with nothing in flight
//           drop_cnt  - dropped-result counter (only with
//                       SQRT_COLLECTOR_STATS_EN defined)
//
// Modports: master - the side driving arg/res/out_ready (source + consumer)
//           slave  - the collector itself
// ---------------------------------------------------------------------------
interface sqrt_result_collector_if #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             arg_vld;
    logic             res_vld;
    logic [31:0]      res;
    logic             out_vld;
    logic             out_ready;
    logic [31:0]      out_data;
    logic [CW-1:0]    fifo_cnt;
    logic [CNT_W-1:0] in_flight;
    logic             stall_req;
    logic             overflow;
    logic             underflow;
`ifdef SQRT_COLLECTOR_STATS_EN
    logic [15:0]      drop_cnt;
`endif

`ifdef SQRT_COLLECTOR_STATS_EN
    modport master (
        output arg_vld, res_vld, res, out_ready,
        input  out_vld, out_data, fifo_cnt, in_flight, stall_req,
               overflow, underflow, drop_cnt
    );
    modport slave (
        input  arg_vld, res_vld, res, out_ready,
        output out_vld, out_data, fifo_cnt, in_flight, stall_req,
               overflow, underflow, drop_cnt
    );
`else
    modport master (
        output arg_vld, res_vld, res, out_ready,
        input  out_vld, out_data, fifo_cnt, in_flight, stall_req,
               overflow, underflow
    );
    modport slave (
        input  arg_vld, res_vld, res, out_ready,
        output out_vld, out_data, fifo_cnt, in_flight, stall_req,
               overflow, underflow
    );
`endif

endinterface

// File: rtl/sqrt_result_collector.sv
// ---------------------------------------------------------------------------
// sqrt_result_collector
//
// Purpose : collects results returning from the upstream sqrt distributor
//           into a DEPTH-entry first-word-fall-through FIFO, tracks how many
//           issued arguments are still outstanding, and raises stall_req
//           early enough that a source obeying it can never overflow the
//           FIFO.  Results are never back-pressured; a result arriving
//           while the FIFO is full and not being read is dropped and the
//           sticky overflow flag is set.
//
// Ports   : clk  - single clock, rising edge
//           rst  - asynchronous, active-low reset
//           bus  - sqrt_result_collector_if.slave (see interface header)
//
// Params  : DEPTH - FIFO entries, power of two, >= 2
//           CNT_W - width of the in-flight counter
//
// Options : define SQRT_COLLECTOR_STATS_EN to add the 16-bit saturating
//           drop_cnt output.
// ---------------------------------------------------------------------------
module sqrt_result_collector #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    sqrt_result_collector_if.slave    bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    // Sum width for stall_req: wide enough that in_flight + fifo_cnt never wraps.
    localparam int SW = ((CNT_W > CW) ? CNT_W : CW) + 1;
    localparam logic [CNT_W-1:0] INF_MAX = '1;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [31:0]      mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0] inflight_q, inflight_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    // -----------------------------------------------------------------------
    // Handshake decode
    // -----------------------------------------------------------------------
    logic empty;
    logic full;
    logic rd_en;
    logic wr_en;
    logic drop;

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == CW'(DEPTH));
    // A read needs a valid head; an empty FIFO ignores out_ready.
    assign rd_en = !empty && bus.out_ready;
    // A full FIFO still accepts a result when the head leaves in the same cycle.
    assign wr_en = bus.res_vld && (!full || rd_en);
    assign drop  = bus.res_vld && !wr_en;

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        inflight_d = inflight_q;
        ovf_d      = ovf_q;
        unf_d      = unf_q;

        // Pointers are AW bits wide, so +1 wraps modulo DEPTH for free.
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        unique case ({wr_en, rd_en})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase

        // Simultaneous issue and return cancel out.
        if (bus.arg_vld && !bus.res_vld) begin
            if (inflight_q != INF_MAX) begin
                inflight_d = inflight_q + CNT_W'(1);
            end
        end else if (bus.res_vld && !bus.arg_vld) begin
            if (inflight_q != '0) begin
                inflight_d = inflight_q - CNT_W'(1);
            end
        end

        // A result with nothing outstanding is still stored; it is only flagged.
        if (bus.res_vld && (inflight_q == '0)) begin
            unf_d = 1'b1;
        end

        if (drop) begin
            ovf_d = 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Control registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            inflight_q <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            inflight_q <= inflight_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
        end
    end

    // -----------------------------------------------------------------------
    // Storage
    //
    // The head entry must be visible the cycle after it is written with no
    // bubble, so the read is combinational from a bank of per-entry
    // registers rather than a registered-read RAM.  Storage is not reset;
    // out_data is only meaningful while out_vld is high.
    // -----------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (wr_en && (wr_ptr_q == AW'(gi))) begin
                    mem_q[gi] <= bus.res;
                end
            end
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Optional drop statistics
    // -----------------------------------------------------------------------
`ifdef SQRT_COLLECTOR_STATS_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign bus.drop_cnt = drop_cnt_q;
`endif

    // -----------------------------------------------------------------------
    // Outputs -- all derived from registers only
    // -----------------------------------------------------------------------
    assign bus.out_vld   = !empty;
    assign bus.out_data  = mem_q[rd_ptr_q];
    assign bus.fifo_cnt  = cnt_q;
    assign bus.in_flight = inflight_q;
    // Every outstanding argument may still land in the FIFO, so stall once
    // the outstanding results plus stored results could fill it.
    assign bus.stall_req = ((SW'(inflight_q) + SW'(cnt_q)) >= SW'(DEPTH));
    assign bus.overflow  = ovf_q;
    assign bus.underflow = unf_q;

endmodule

// File: tb/tb_sqrt_result_collector.sv
// ---------------------------------------------------------------------------
// tb_sqrt_result_collector
//
// Bench for sqrt_result_collector (DEPTH=8, CNT_W=8).  A queue-based model
// of the collector is compared against the DUT on every cycle; scripted
// scenarios add literal expectations, followed by a randomized phase.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sqrt_result_collector;

    localparam int DEPTH = 8;
    localparam int CNT_W = 8;
    localparam int INF_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    sqrt_result_collector_if #(.DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

    sqrt_result_collector #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_err    = 0;
    int n_checks = 0;

    // Behavioural model state
    logic [31:0] m_q[$];
    int          m_inf;
    bit          m_ovf;
    bit          m_unf;
    int          m_drop;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_inf  = 0;
        m_ovf  = 0;
        m_unf  = 0;
        m_drop = 0;
    endtask

    function automatic bit m_stall();
        return (m_inf + m_q.size()) >= DEPTH;
    endfunction

    // Called at the falling edge: compare DUT outputs to the model, then
    // advance the model by the rising edge that follows.
    task automatic model_cycle();
        bit rd, wr, drp;
        chk("out_vld",   bus.out_vld,   32'(m_q.size() != 0));
        chk("fifo_cnt",  bus.fifo_cnt,  32'(m_q.size()));
        chk("in_flight", bus.in_flight, 32'(m_inf));
        chk("stall_req", bus.stall_req, 32'(m_stall()));
        chk("overflow",  bus.overflow,  32'(m_ovf));
        chk("underflow", bus.underflow, 32'(m_unf));
        if (m_q.size() != 0) chk("out_data", bus.out_data, m_q[0]);
`ifdef SQRT_COLLECTOR_STATS_EN
        chk("drop_cnt",  bus.drop_cnt,  32'(m_drop));
`endif
        if (!rst) begin
            model_reset();
            return;
        end
        rd  = (m_q.size() != 0) && bus.out_ready;
        wr  = bus.res_vld && ((m_q.size() < DEPTH) || rd);
        drp = bus.res_vld && !wr;
        if (rd || wr || drp)
            $display("t=%0t rd=%0b rd_data=%0d wr=%0b wr_data=%0d drop=%0b",
                     $time, rd, rd ? m_q[0] : 32'd0, wr, bus.res, drp);
        if (rd) void'(m_q.pop_front());
        if (wr) m_q.push_back(bus.res);
        if (drp) begin
            m_ovf = 1;
            if (m_drop < 16'hFFFF) m_drop++;
        end
        if (bus.res_vld && m_inf == 0) m_unf = 1;
        if (bus.arg_vld && !bus.res_vld) begin
            if (m_inf < INF_MAX) m_inf++;
        end else if (bus.res_vld && !bus.arg_vld) begin
            if (m_inf > 0) m_inf--;
        end
    endtask

    task automatic drive(input bit a, input bit r, input logic [31:0] v, input bit rdy);
        bus.arg_vld   = a;
        bus.res_vld   = r;
        bus.res       = v;
        bus.out_ready = rdy;
    endtask

    // Inputs change at posedge+1; each step checks and advances one cycle.
    task automatic step();
        @(negedge clk);
        model_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        model_reset();
        #1;
        chk("rst_fifo_cnt", bus.fifo_cnt, 32'd0);
        chk("rst_out_vld",  bus.out_vld,  32'd0);
        drive(0, 0, 0, 0);
        step();
        rst = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] drain_exp [8];
        bit          issued [0:127];
        bit          stall_seen;
        int          p_arg, p_res, p_rdy;

        drain_exp = '{32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8, 32'd42};
        drive(0, 0, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("init_out_vld",   bus.out_vld,   32'd0);
        chk("init_fifo_cnt",  bus.fifo_cnt,  32'd0);
        chk("init_in_flight", bus.in_flight, 32'd0);
        chk("init_stall",     bus.stall_req, 32'd0);
        chk("init_overflow",  bus.overflow,  32'd0);
        chk("init_underflow", bus.underflow, 32'd0);
        rst = 1'b1;

        // Single pass: argument, result 9 three cycles later
        drive(1, 0, 0, 1); step();
        chk("single_inflight1", bus.in_flight, 32'd1);
        drive(0, 0, 0, 1); step(); step();
        drive(0, 1, 32'd9, 1); step();
        chk("single_out_vld",   bus.out_vld,   32'd1);
        chk("single_out_data",  bus.out_data,  32'd9);
        chk("single_inflight0", bus.in_flight, 32'd0);
        drive(0, 0, 0, 1); step();
        chk("single_drained", bus.out_vld, 32'd0);

        // Fill with 1..8, no reads
        for (int i = 1; i <= 8; i++) begin
            drive(0, 1, 32'(i), 0); step();
        end
        chk("fill_cnt",       bus.fifo_cnt,  32'd8);
        chk("fill_stall",     bus.stall_req, 32'd1);
        chk("fill_underflow", bus.underflow, 32'd1);

        // Ninth result while full and not reading is dropped
        drive(0, 1, 32'd99, 0); step();
        chk("ovf_flag", bus.overflow, 32'd1);
        chk("ovf_cnt",  bus.fifo_cnt, 32'd8);
`ifdef SQRT_COLLECTOR_STATS_EN
        chk("ovf_drop_cnt", bus.drop_cnt, 32'd1);
`endif

        // Full with simultaneous read and write
        drive(0, 1, 32'd42, 1); step();
        chk("rw_full_cnt", bus.fifo_cnt, 32'd8);
`ifdef SQRT_COLLECTOR_STATS_EN
        chk("rw_full_drop_cnt", bus.drop_cnt, 32'd1);
`endif
        for (int k = 0; k < 8; k++) begin
            drive(0, 0, 0, 1);
            chk($sformatf("drain_%0d", k), bus.out_data, drain_exp[k]);
            step();
        end
        chk("drain_empty", bus.out_vld, 32'd0);

        // Reset mid-stream with 5 entries queued
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(0, 1, 32'(100 + i), 0); step();
        end
        chk("mid_cnt5", bus.fifo_cnt, 32'd5);
        rst = 1'b0;
        model_reset();
        #1;
        chk("mid_rst_out_vld", bus.out_vld,   32'd0);
        chk("mid_rst_cnt",     bus.fifo_cnt,  32'd0);
        chk("mid_rst_unf",     bus.underflow, 32'd0);
        drive(0, 0, 0, 0); step();
        rst = 1'b1;
        drive(0, 1, 32'd7, 0); step();
        chk("post_rst_underflow", bus.underflow, 32'd1);
        chk("post_rst_inflight",  bus.in_flight, 32'd0);
        chk("post_rst_cnt",       bus.fifo_cnt,  32'd1);

        // in_flight saturation
        do_reset();
        for (int i = 0; i < INF_MAX + 5; i++) begin
            drive(1, 0, 0, 0); step();
        end
        chk("inflight_sat", bus.in_flight, 32'(INF_MAX));
        chk("sat_stall",    bus.stall_req, 32'd1);

        // Continuous stream, source obeys stall_req, 13-cycle return latency
        do_reset();
        stall_seen = 0;
        for (int c = 0; c < 128; c++) issued[c] = 0;
        for (int c = 0; c < 80; c++) begin
            bit a, r;
            a = (c < 40) && !m_stall();
            r = (c >= 13) && issued[c - 13];
            issued[c] = a;
            drive(a, r, 32'(1000 + c), (c % 2) == 0);
            step();
            chk("stream_inflight_le13", 32'(bus.in_flight <= 13), 32'd1);
            if (bus.stall_req) stall_seen = 1;
        end
        chk("stream_stall_seen", 32'(stall_seen), 32'd1);
        chk("stream_no_ovf",     bus.overflow,    32'd0);
        chk("stream_inflight0",  bus.in_flight,   32'd0);

        // Randomized traffic with occasional resets
        do_reset();
        for (int seg = 0; seg < 6; seg++) begin
            p_arg = $urandom_range(10, 90);
            p_res = $urandom_range(10, 90);
            p_rdy = $urandom_range(5, 95);
            for (int c = 0; c < 250; c++) begin
                if ($urandom_range(0, 299) == 0) begin
                    do_reset();
                end else begin
                    drive($urandom_range(0, 99) < p_arg, $urandom_range(0, 99) < p_res,
                          $urandom, $urandom_range(0, 99) < p_rdy);
                    step();
                end
            end
        end
        drive(0, 0, 0, 0);
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
